// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI-Stream header insert/remove blocks.
// Contents:
//   hdr_state_e  - packet FSM states (idle, mid-packet body, residual tail)
//   BYTE_BITS    - bits per stream byte
//   byte_bits()  - converts a byte count into a bit count for shift amounts
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBody = 2'd1,
    StTail = 2'd2
  } hdr_state_e;

  localparam int unsigned BYTE_BITS = 8;

  function automatic int unsigned byte_bits(input int unsigned n);
    return n * BYTE_BITS;
  endfunction

endpackage

// File: rtl/axis_byte_shift.sv
// Combinational byte merge used by the header insert/remove datapath.
// The current beat is moved up by len bytes and the low len bytes are taken from carry.
// The top len bytes of the current beat are returned, low-aligned, as the next carry.
// Ports:
//   len             - shift in bytes (0..STRB_WIDTH)
//   cur_data/keep   - current beat
//   carry_data/keep - bytes to place in the low len lanes
//   merged_data/keep     - {cur low bytes, carry low len bytes}
//   next_carry_data/keep - top len bytes of the current beat, moved to lane 0
module axis_byte_shift
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] cur_data,
  input  logic [STRB_WIDTH-1:0] cur_keep,
  input  logic [DATA_WIDTH-1:0] carry_data,
  input  logic [STRB_WIDTH-1:0] carry_keep,
  output logic [DATA_WIDTH-1:0] merged_data,
  output logic [STRB_WIDTH-1:0] merged_keep,
  output logic [DATA_WIDTH-1:0] next_carry_data,
  output logic [STRB_WIDTH-1:0] next_carry_keep
);

  localparam int unsigned Strb = STRB_WIDTH;

  int unsigned sh;

  always_comb begin
    sh          = 32'(len);
    merged_data = cur_data << byte_bits(sh);
    merged_keep = cur_keep << sh;
    for (int unsigned i = 0; i < Strb; i++) begin
      if (i < sh) begin
        merged_data[i*BYTE_BITS +: BYTE_BITS] = carry_data[i*BYTE_BITS +: BYTE_BITS];
        merged_keep[i]                        = carry_keep[i];
      end
    end
    // A shift of the full width (len == 0) yields an empty carry.
    next_carry_data = cur_data >> byte_bits(Strb - sh);
    next_carry_keep = cur_keep >> (Strb - sh);
  end

endmodule

// File: rtl/hdr_insert_var.sv
// Prepends a variable-length header (0..HDR_BYTES_MAX bytes) to each AXI-Stream packet.
// One header is consumed per packet, together with the packet's first beat.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   s_axis_*                 - payload stream in (tkeep contiguous from bit 0)
//   header, header_len       - header bytes (byte 0 in LSBs, sent first) and byte count
//   header_valid/ready       - header handshake, ready only on a first-beat accept
//   m_axis_*                 - output stream, one register stage
module hdr_insert_var
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int HDR_BYTES_MAX = 8,
  parameter int DEST_WIDTH    = 8,
  parameter int USER_WIDTH    = 8,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int LEN_WIDTH     = $clog2(HDR_BYTES_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [STRB_WIDTH-1:0]      s_axis_tkeep,
  input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [HDR_BYTES_MAX*8-1:0] header,
  input  logic [LEN_WIDTH-1:0]       header_len,
  input  logic                       header_valid,
  output logic                       header_ready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [STRB_WIDTH-1:0]      m_axis_tkeep,
  output logic [DEST_WIDTH-1:0]      m_axis_tdest,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  hdr_state_e state;

  logic [LEN_WIDTH-1:0]  len_q, len_eff, len_sel;
  logic [DATA_WIDTH-1:0] carry_data, hdr_ext, sel_carry_data, merged_data, next_carry_data;
  logic [STRB_WIDTH-1:0] carry_keep, hdr_keep, sel_carry_keep, merged_keep, next_carry_keep;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [USER_WIDTH-1:0] user_q;
  logic                  first, out_ready, s_fire;

  always_comb begin
    len_eff = (header_len > LEN_WIDTH'(HDR_BYTES_MAX)) ? LEN_WIDTH'(HDR_BYTES_MAX) : header_len;
    hdr_ext = '0;
    hdr_ext[HDR_BYTES_MAX*8-1:0] = header;
    hdr_keep = '0;
    for (int unsigned i = 0; i < HDR_BYTES_MAX; i++) begin
      if (i < 32'(len_eff)) hdr_keep[i] = 1'b1;
    end

    // On the first beat the header plays the role of the carry.
    first          = (state == StIdle);
    len_sel        = first ? len_eff : len_q;
    sel_carry_data = first ? hdr_ext : carry_data;
    sel_carry_keep = first ? hdr_keep : carry_keep;

    out_ready = !m_axis_tvalid || m_axis_tready;
    unique case (state)
      StIdle:  s_axis_tready = header_valid && out_ready;
      StBody:  s_axis_tready = out_ready;
      default: s_axis_tready = 1'b0;
    endcase
    if (rst) s_axis_tready = 1'b0;
    header_ready = first && s_axis_tvalid && header_valid && out_ready && !rst;
    s_fire       = s_axis_tvalid && s_axis_tready;
  end

  axis_byte_shift #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_shift (
    .len             (len_sel),
    .cur_data        (s_axis_tdata),
    .cur_keep        (s_axis_tkeep),
    .carry_data      (sel_carry_data),
    .carry_keep      (sel_carry_keep),
    .merged_data     (merged_data),
    .merged_keep     (merged_keep),
    .next_carry_data (next_carry_data),
    .next_carry_keep (next_carry_keep)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (out_ready) m_axis_tvalid <= 1'b0;
      unique case (state)
        StIdle, StBody: begin
          if (s_fire) begin
            m_axis_tdata  <= merged_data;
            m_axis_tkeep  <= merged_keep;
            m_axis_tvalid <= 1'b1;
            m_axis_tdest  <= first ? s_axis_tdest : dest_q;
            m_axis_tuser  <= first ? s_axis_tuser : user_q;
            carry_data    <= next_carry_data;
            carry_keep    <= next_carry_keep;
            if (first) begin
              len_q  <= len_eff;
              dest_q <= s_axis_tdest;
              user_q <= s_axis_tuser;
            end
            if (s_axis_tlast) begin
              // Bytes pushed past the top lane need one extra beat.
              if (|next_carry_keep) begin
                state        <= StTail;
                m_axis_tlast <= 1'b0;
              end else begin
                state        <= StIdle;
                m_axis_tlast <= 1'b1;
              end
            end else begin
              state        <= StBody;
              m_axis_tlast <= 1'b0;
            end
          end
        end
        StTail: begin
          if (out_ready) begin
            m_axis_tdata  <= carry_data;
            m_axis_tkeep  <= carry_keep;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            m_axis_tdest  <= dest_q;
            m_axis_tuser  <= user_q;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
